branch_redirect_ctrl: RTL

Sequencing controller for the RV32I core's branch/jump resolution path. It accepts a decoded control-transfer instruction and holds further fetch of control transfers until the branch unit's multi-cycle resolution completes. It then samples the taken condition and target, issues a single redirect to the fetch stage, and drives a fixed-length flush of wrong-path instructions. It also keeps saturating performance counters of control transfers and taken transfers.

---
 rtl/branch_redirect_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// branch_redirect_ctrl
//
// Sequences one control-transfer instruction (branch / JAL / JALR) at a time
// through the branch unit's multi-cycle resolution. Once the transfer is
// resolved it issues a single fetch redirect for a taken transfer and then
// holds `flush` for a fixed number of cycles to squash wrong-path
// instructions. It also keeps saturating counts of accepted and taken
// control transfers.
//
// Parameters:
//   RESOLVE_LAT  cycles from accept to the cycle where cond/pc_jmpto are valid (>=1)
//   FLUSH_DEPTH  cycles flush is held after a redirect (>=1)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   stall           freezes the RESOLVE countdown, REDIRECT and FLUSH
//   dec_valid       decode-stage instruction valid
//   dec_b_type      conditional branch
//   dec_jal         JAL
//   dec_jalr        JALR
//   cond            branch condition, sampled only in the resolve cycle
//   pc_jmpto        branch target, sampled only in the resolve cycle
//   redirect_valid  fetch redirect request (state REDIRECT)
//   redirect_pc     redirect target, bit 0 always 0; holds its last value
//   fetch_hold      a control transfer is in flight
//   flush           squash wrong-path instructions (state FLUSH)
//   busy            state != IDLE
//   protocol_err    sticky: a control transfer arrived while busy
//   branch_cnt      accepted control transfers (saturating)
//   taken_cnt       taken control transfers (saturating)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module branch_redirect_ctrl #(
  parameter int RESOLVE_LAT = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             dec_valid,
  input  logic             dec_b_type,
  input  logic             dec_jal,
  input  logic             dec_jalr,
  input  logic             cond,
  input  logic [31:0]      pc_jmpto,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             fetch_hold,
  output logic             flush,
  output logic             busy,
  output logic             protocol_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Countdown widths sized so the load value (N-1) always fits.
  localparam int LAT_W = (RESOLVE_LAT > 1) ? $clog2(RESOLVE_LAT) : 1;
  localparam int FL_W  = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESOLVE_LAT - 1);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLUSH_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESOLVE,
    ST_REDIRECT,
    ST_FLUSH
  } state_t;

  typedef enum logic [1:0] {
    K_BRANCH,
    K_JAL,
    K_JALR
  } kind_t;

  state_t           state_reg;
  kind_t            kind_reg;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [FL_W-1:0]  fl_cnt_reg;
  logic [31:0]      redirect_pc_reg;
  logic             protocol_err_reg;
  logic [CNT_W-1:0] branch_cnt_reg;
  logic [CNT_W-1:0] taken_cnt_reg;

  logic ctrl_xfer;
  logic resolve_taken;

  assign ctrl_xfer = dec_valid & (dec_b_type | dec_jal | dec_jalr);

  // Jumps are always taken; only a conditional branch looks at cond.
  assign resolve_taken = (kind_reg != K_BRANCH) || cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      kind_reg         <= K_BRANCH;
      lat_cnt_reg      <= '0;
      fl_cnt_reg       <= '0;
      redirect_pc_reg  <= '0;
      protocol_err_reg <= 1'b0;
      branch_cnt_reg   <= '0;
      taken_cnt_reg    <= '0;
    end else begin
      // Any transfer offered while one is in flight is dropped and flagged,
      // whether or not the pipeline is stalled.
      if (ctrl_xfer && (state_reg != ST_IDLE)) begin
        protocol_err_reg <= 1'b1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (ctrl_xfer && !stall) begin
            // Priority jal > jalr > b_type when decode sets several flags.
            if (dec_jal) begin
              kind_reg <= K_JAL;
            end else if (dec_jalr) begin
              kind_reg <= K_JALR;
            end else begin
              kind_reg <= K_BRANCH;
            end
            lat_cnt_reg <= LAT_LOAD;
            if (branch_cnt_reg != '1) begin
              branch_cnt_reg <= branch_cnt_reg + CNT_W'(1);
            end
            state_reg <= ST_RESOLVE;
          end
        end

        ST_RESOLVE: begin
          if (!stall) begin
            if (lat_cnt_reg != '0) begin
              lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
            end else if (resolve_taken) begin
              // Masking rather than slicing keeps every target bit in use.
              redirect_pc_reg <= pc_jmpto & ~32'h0000_0001;
              if (taken_cnt_reg != '1) begin
                taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
              end
              state_reg <= ST_REDIRECT;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end

        ST_REDIRECT: begin
          if (!stall) begin
            fl_cnt_reg <= FL_LOAD;
            state_reg  <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (!stall) begin
            if (fl_cnt_reg != '0) begin
              fl_cnt_reg <= fl_cnt_reg - FL_W'(1);
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign redirect_valid = (state_reg == ST_REDIRECT);
  assign flush          = (state_reg == ST_FLUSH);
  assign busy           = (state_reg != ST_IDLE);
  assign fetch_hold     = (state_reg != ST_IDLE);
  assign redirect_pc    = redirect_pc_reg;
  assign protocol_err   = protocol_err_reg;
  assign branch_cnt     = branch_cnt_reg;
  assign taken_cnt      = taken_cnt_reg;

endmodule
